// File: rtl/aes_seq_pkg.sv
// Shared types and round constants for the AES input sequencer.
package aes_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_KEY = 2'd0,
    IDLE     = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int unsigned NR_W = 4;

  localparam logic [NR_W-1:0] NR128 = 4'd10;
  localparam logic [NR_W-1:0] NR192 = 4'd12;
  localparam logic [NR_W-1:0] NR256 = 4'd14;

  // Round count for a key-size mode; the reserved encoding runs as AES-128.
  function automatic logic [NR_W-1:0] nr_of(input logic [1:0] mode);
    case (mode_e'(mode))
      MODE_192: return NR192;
      MODE_256: return NR256;
      default:  return NR128;
    endcase
  endfunction

endpackage

// File: rtl/aes_in_capture.sv
// Block capture register for the AES input sequencer.
// Define AES_IN_BYTE_SWAP_EN to byte-reverse every word on capture (WORD_W must be a multiple of 8).
module aes_in_capture
  import aes_seq_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [WORD_W*NUM_WORDS-1:0]   data_i,
  output logic [WORD_W*NUM_WORDS-1:0]   blk_o
);

  localparam int unsigned BLK_W = WORD_W * NUM_WORDS;

  logic [BLK_W-1:0] blk_d;
  logic [BLK_W-1:0] blk_q;

`ifdef AES_IN_BYTE_SWAP_EN
  localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

  // Reverse byte order within each word, word positions unchanged.
  always_comb begin
    blk_d = data_i;
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
        blk_d[w*int'(WORD_W) + b*8 +: 8] =
          data_i[w*int'(WORD_W) + (int'(BYTES_PER_WORD) - 1 - b)*8 +: 8];
      end
    end
  end
`else
  assign blk_d = data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_q <= '0;
    end else if (en_i) begin
      blk_q <= blk_d;
    end
  end

  assign blk_o = blk_q;

endmodule

// File: rtl/aes_in_sequencer.sv
// Input-fetch and load-window sequencer for the AES core: key-setup wait, block accept, timed RUN.
// Optional AES_IN_BYTE_SWAP_EN byte-reverses each captured word; timing is unaffected.
module aes_in_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned WORD_W           = 32,
  parameter int unsigned NUM_WORDS        = 4,
  parameter int unsigned KEY_SETUP_CYCLES = 18,
  parameter int unsigned PAD_CYCLES       = 6,
  parameter int unsigned CNT_W            = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  mode_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [WORD_W*NUM_WORDS-1:0] in_data_i,
  output logic [WORD_W*NUM_WORDS-1:0] blk_data_o,
  output logic                        load_o,
  output logic                        start_o,
  output logic                        key_rst_o,
  output logic                        busy_o,
  output logic                        mode_err_o
);

  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] KEY_PRE  = CNT_W'(KEY_SETUP_CYCLES - 2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_q;
  logic [CNT_W-1:0] last_d;
  logic             load_q;
  logic             start_q;
  logic             key_rst_q;
  logic             busy_q;
  logic             mode_err_q;
  logic             accept;

  assign in_ready_o = (state_q == IDLE) || (state_q == DRAIN);
  assign accept     = in_valid_i && in_ready_o;

  // Terminal RUN count for the incoming block: NR + PAD_CYCLES cycles, counted from 0.
  assign last_d = CNT_W'(nr_of(mode_i)) + CNT_W'(PAD_CYCLES - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WAIT_KEY;
      cnt_q      <= '0;
      last_q     <= '0;
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      key_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      key_rst_q  <= 1'b0;
      mode_err_q <= 1'b0;
      unique case (state_q)
        WAIT_KEY: begin
          // key_rst lands in the last key-setup cycle, so it is set one count early.
          key_rst_q <= (cnt_q == KEY_PRE);
          if (cnt_q == KEY_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IDLE, DRAIN: begin
          if (accept) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            last_q     <= last_d;
            load_q     <= 1'b1;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            mode_err_q <= (mode_i == MODE_RSVD);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q == last_q) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
            load_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= WAIT_KEY;
      endcase
    end
  end

  aes_in_capture #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_capture (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (accept),
    .data_i (in_data_i),
    .blk_o  (blk_data_o)
  );

  assign load_o     = load_q;
  assign start_o    = start_q;
  assign key_rst_o  = key_rst_q;
  assign busy_o     = busy_q;
  assign mode_err_o = mode_err_q;

endmodule

// File: tb/tb_aes_in_sequencer.sv
// Scoreboard bench for aes_in_sequencer: stimulus pushes expected load windows, a monitor checks them.
module tb_aes_in_sequencer;

  typedef struct {
    logic [127:0] blk;
    int           len;
    int           merr;
    bit           b2b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] blk_data;
  logic         load, start, key_rst, busy, mode_err;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  aes_in_sequencer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mode_i     (mode),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .blk_data_o (blk_data),
    .load_o     (load),
    .start_o    (start),
    .key_rst_o  (key_rst),
    .busy_o     (busy),
    .mode_err_o (mode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_blk(input logic [127:0] d);
    logic [127:0] r;
    r = d;
`ifdef AES_IN_BYTE_SWAP_EN
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        r[w*32 + b*8 +: 8] = d[w*32 + (3-b)*8 +: 8];
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d, input int len, input int merr, input bit b2b);
    exp_t e;
    e.blk = exp_blk(d); e.len = len; e.merr = merr; e.b2b = b2b;
    sb.push_back(e);
  endtask

  // Key-setup window: key_rst only in cycle 17, in_ready first in cycle 18.
  task automatic key_setup_check(input string tag);
    for (int c = 0; c < 18; c++) begin
      chk($sformatf("%s key_rst c%0d", tag, c), {127'b0, key_rst}, {127'b0, (c == 17)});
      chk($sformatf("%s in_ready c%0d", tag, c), {127'b0, in_ready}, 128'd0);
      tick();
    end
    chk({tag, " in_ready c18"}, {127'b0, in_ready}, 128'd1);
  endtask

  // Monitor: measures every load window and compares it with the scoreboard head.
  logic         load_prev = 1'b0;
  int           win_len = 0, gap = 1000, gap_at_rise = 0, merr_cnt = 0;
  logic [127:0] blk_seen;
  bit           start_first = 0, start_extra = 0, unstable = 0;

  always @(negedge clk) begin
    if (load && !load_prev) begin
      win_len = 1; blk_seen = blk_data; start_first = start; start_extra = 0;
      merr_cnt = int'(mode_err); unstable = 0; gap_at_rise = gap;
    end else if (load) begin
      win_len++;
      if (blk_data !== blk_seen) unstable = 1;
      if (start) start_extra = 1;
      merr_cnt += int'(mode_err);
    end else if (load_prev) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected load window: len %0d blk %h", win_len, blk_seen);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("win blk_data", blk_seen, e.blk);
        chk("win length", 128'(win_len), 128'(e.len));
        chk("win start first cycle", {127'b0, start_first}, 128'd1);
        chk("win start single", {127'b0, start_extra}, 128'd0);
        chk("win mode_err pulses", 128'(merr_cnt), 128'(e.merr));
        chk("win blk stable", {127'b0, unstable}, 128'd0);
        if (e.b2b) chk("win b2b gap", 128'(gap_at_rise), 128'd1);
      end
      gap = 1;
    end else begin
      gap++;
    end
    load_prev = load;
  end

  localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D1 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D3 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D4 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;

  initial begin
    rst = 1'b1; mode = 2'd0; in_valid = 1'b1; in_data = D3;
    tick(); tick();
    chk("rst in_ready", {127'b0, in_ready}, 128'd0);
    chk("rst load",     {127'b0, load},     128'd0);
    chk("rst start",    {127'b0, start},    128'd0);
    chk("rst key_rst",  {127'b0, key_rst},  128'd0);
    chk("rst busy",     {127'b0, busy},     128'd0);
    chk("rst mode_err", {127'b0, mode_err}, 128'd0);
    chk("rst blk_data", blk_data,           128'd0);

    // in_valid stays high through key setup and must be ignored.
    rst = 1'b0;
    key_setup_check("init");
    in_valid = 1'b0;
    tick();

    // Single mode-0 block.
    push(D0, 16, 0, 0);
    in_valid = 1'b1; in_data = D0; mode = 2'd0;
    tick();
    in_valid = 1'b0; in_data = D4;
    chk("single first load", {127'b0, load}, 128'd1);
    chk("single start", {127'b0, start}, 128'd1);
    chk("single busy", {127'b0, busy}, 128'd1);
    chk("single in_ready run", {127'b0, in_ready}, 128'd0);
`ifdef AES_IN_BYTE_SWAP_EN
    chk("swap word2", {96'b0, blk_data[95:64]}, 128'h77665544);
`else
    chk("plain word2", {96'b0, blk_data[95:64]}, 128'h44556677);
`endif
    repeat (16) tick();
    chk("drain load", {127'b0, load}, 128'd0);
    chk("drain busy", {127'b0, busy}, 128'd1);
    chk("drain in_ready", {127'b0, in_ready}, 128'd1);
    tick();
    chk("idle busy", {127'b0, busy}, 128'd0);
    chk("idle in_ready", {127'b0, in_ready}, 128'd1);

    // Back-to-back: mode 1 then mode 2, second accept in DRAIN.
    push(D1, 18, 0, 0);
    push(D2, 20, 0, 1);
    in_valid = 1'b1; in_data = D1; mode = 2'd1;
    tick();
    in_data = D2; mode = 2'd2;
    repeat (18) tick();
    chk("b2b drain in_ready", {127'b0, in_ready}, 128'd1);
    chk("b2b drain busy", {127'b0, busy}, 128'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b second start", {127'b0, start}, 128'd1);
    repeat (20) tick();
    tick();
    chk("b2b idle busy", {127'b0, busy}, 128'd0);

    // Reserved mode runs as 128 and flags mode_err.
    push(D3, 16, 1, 0);
    in_valid = 1'b1; in_data = D3; mode = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("rsvd mode_err", {127'b0, mode_err}, 128'd1);
    tick();
    chk("rsvd mode_err single", {127'b0, mode_err}, 128'd0);
    repeat (17) tick();

    // Abort mid-RUN with reset at RUN cycle 5.
    push(D4, 6, 0, 0);
    in_valid = 1'b1; in_data = D4; mode = 2'd0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("abort load", {127'b0, load}, 128'd0);
    chk("abort blk_data", blk_data, 128'd0);
    chk("abort busy", {127'b0, busy}, 128'd0);
    chk("abort in_ready", {127'b0, in_ready}, 128'd0);
    rst = 1'b0;
    key_setup_check("abort");
    repeat (3) tick();
    chk("scoreboard drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_in_sequencer.md
Name: aes_in_sequencer

Overview:
- Parametrised input-fetch and timing sequencer for the AES datapath.
- Accepts plaintext blocks over a valid/ready handshake and holds each block stable for the core.
- Drives the core's load window, with length set per block by key-size mode (10/12/14 rounds).
- Issues a single-cycle key_rst pulse once key setup finishes after reset.

Parameters:
WORD_W, 32, bits per data word
NUM_WORDS, 4, words per block; block width BLK_W = WORD_W*NUM_WORDS
KEY_SETUP_CYCLES, 18, cycles from reset release to end of key setup; must be >= 2
PAD_CYCLES, 6, extra load-high cycles added to the round count
CNT_W, 5, width of cycle counters; must hold max(KEY_SETUP_CYCLES, 14+PAD_CYCLES)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
mode  in  2  key size: 0=128, 1=192, 2=256, 3=reserved; sampled on accept
in_valid  in  1  source presents block
in_ready  out  1  sequencer can accept
in_data  in  BLK_W  plaintext block, word 0 in LSBs
blk_data  out  BLK_W  captured block held for the core
load  out  1  core load/run window
start  out  1  one-cycle pulse, first cycle of each load window
key_rst  out  1  one-cycle key-schedule reset pulse
busy  out  1  high in RUN and DRAIN
mode_err  out  1  one-cycle pulse when a block is accepted with mode==3

Behaviour:
- Reset values: in_ready=0, load=0, start=0, key_rst=0, busy=0, mode_err=0, blk_data=0, all counters 0, state=WAIT_KEY.
- Reset is synchronous. rst in any state, including mid-RUN, aborts the current block and restarts the key-setup count.
- All outputs are registered except in_ready, which is a decode of the state register.
- Accept occurs on a rising edge where in_valid && in_ready.
- WAIT_KEY:
  - Counter counts cycles 0..KEY_SETUP_CYCLES-1 after reset release.
  - key_rst=1 only during cycle KEY_SETUP_CYCLES-1.
  - Next cycle goes to IDLE.
  - in_ready=0 throughout; in_valid is ignored.
- IDLE:
  - in_ready=1.
  - On accept: blk_data<=in_data; mode is latched and NR is set (10/12/14; mode 3 gives NR=10 and mode_err=1 in the next cycle); go to RUN.
- RUN:
  - Lasts exactly NR+PAD_CYCLES cycles (default 16/18/20).
  - load=1 and busy=1 throughout; start=1 only in the first RUN cycle.
  - in_ready=0; blk_data is held stable.
  - Then go to DRAIN.
- DRAIN:
  - Lasts 1 cycle; load=0, busy=1, in_ready=1.
  - Accept in DRAIN: capture and go straight to RUN (back-to-back).
  - No accept: go to IDLE.
- Latency and throughput:
  - Accept edge to first load=1 cycle: 1 cycle.
  - Back-to-back throughput: one block per NR+PAD_CYCLES+1 cycles.
- Counters never wrap; a RUN counter hitting its terminal value forces the transition.
- in_data and mode are don't-care when no accept occurs.

Optional Feature:
- Macro: AES_IN_BYTE_SWAP_EN.
- Defined: on capture, each WORD_W word of in_data is byte-reversed before being stored in blk_data. Requires WORD_W%8==0.
- Undefined: blk_data = in_data verbatim.
- Timing is identical either way.

Decomposition:
- Shared package aes_seq_pkg holds:
  - state enum (WAIT_KEY, IDLE, RUN, DRAIN)
  - mode encodings
  - round constants NR128=10, NR192=12, NR256=14
  - function nr_of(mode)
- Natural sub-module aes_in_capture: block register plus the optional byte swap, enabled by the accept strobe.

Test Plan:
- Key setup: rst for 2 cycles, then release → key_rst high only in cycle 17 after release; in_ready first high in cycle 18; in_valid held high during WAIT_KEY is not accepted.
- Single block, mode 0: accept in_data=0x00112233_44556677_8899AABB_CCDDEEFF → blk_data equals it; start pulses 1 cycle later; load high exactly 16 cycles, then DRAIN, then IDLE.
- Back-to-back, modes 1 then 2 with in_valid held high → load windows of 18 and 20 cycles separated by exactly one load=0 cycle; second accept happens in DRAIN.
- Mode 3 → mode_err pulses once; load high 16 cycles.
- rst asserted at RUN cycle 5 → next cycle load=0, blk_data=0, state WAIT_KEY; key_rst re-pulses in cycle 17 after release.
- With AES_IN_BYTE_SWAP_EN, word 0x44556677 captured → 0x77665544.
